sa_input_loader: RTL and testbench
==================================

# sa_input_loader

Reads a block of activation/weight rows from an on-chip BRAM and streams them into the PE_SIZE per-row input FIFOs of the systolic array. Lane i is delayed by i cycles, which produces the diagonal wavefront the array expects. It is the read-side counterpart of the output data mover: memory to skewed FIFOs, instead of skewed FIFOs to memory. Controlled by a start/done handshake from the GEMM controller.

## Interface
- FIFO_DATA_WIDTH, 8, width of one lane element
- PE_SIZE, 16, number of lanes (array rows); ≥2
- MEM_ADDR_WIDTH, 10, BRAM address width
- MEM_DATA_WIDTH, 128, BRAM word width; must equal FIFO_DATA_WIDTH*PE_SIZE
- ROWS, 64, BRAM words transferred per start; ≥1
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle request; sampled only when idle
- base_addr_i  in  MEM_ADDR_WIDTH  first BRAM address; captured with start_i
- fifo_afull_i  in  PE_SIZE  per-lane FIFO almost-full
- mem_ce_o  out  1  BRAM read enable
- mem_addr_o  out  MEM_ADDR_WIDTH  BRAM read address
- mem_q_i  in  MEM_DATA_WIDTH  BRAM read data, valid 1 cycle after mem_ce_o
- wren_o  out  PE_SIZE  per-lane FIFO write enable
- wdata_o  out  FIFO_DATA_WIDTH*PE_SIZE  per-lane FIFO write data
- busy_o  out  1  high from the cycle after accepted start until done
- done_o  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE: when start_i=1, capture base_addr_i, clear the read counter, and go to READ. busy_o=1 from the next cycle.
- READ: each cycle with |fifo_afull_i=0, assert mem_ce_o, drive mem_addr_o = base + read count, and increment the count.
  - When |fifo_afull_i=1, mem_ce_o=0 and the address and count hold.
  - After the ROWS-th read is issued, go to DRAIN.
- DRAIN: count PE_SIZE+1 cycles, then return to IDLE and pulse done_o.
- Address arithmetic is modulo 2^MEM_ADDR_WIDTH; base+ROWS overflow wraps to 0 with no error.
- Lane mapping (MSB-first):
  - lane i = mem_q_i[MEM_DATA_WIDTH-1-i*FIFO_DATA_WIDTH -: FIFO_DATA_WIDTH].
  - Lane i is written to wdata_o at the same bit slice.
- Skew pipeline:
  - A stage-0 register captures mem_q_i and a valid bit one cycle after each read.
  - Lane i passes through i further register stages, so lane i data and wren_o[i] trail lane 0 by exactly i cycles.
  - The pipeline never stalls. fifo_afull_i only gates new reads, so the FIFOs must have ≥PE_SIZE+1 free entries when almost-full asserts.
- wdata_o lanes with wren_o[i]=0 hold their last value (don't-care for the FIFO).
- start_i while busy_o=1 is ignored; it is neither queued nor does it alter base/count.
- fifo_afull_i has no effect in IDLE or DRAIN.

## Timing
- Reset values: mem_ce_o=0, mem_addr_o=0, wren_o=0, wdata_o=0, busy_o=0, done_o=0; FSM=IDLE; all skew valids cleared.
- With start_i high in cycle 0 and no back-pressure:
  - Reads are issued in cycles 1..ROWS.
  - A read issued in cycle c gives wren_o[0]=1 in c+2 and wren_o[i]=1 in c+2+i.
- If the last read is issued in cycle L:
  - The last lane (PE_SIZE-1) writes in cycle L+PE_SIZE+1.
  - done_o=1 in cycle L+PE_SIZE+2, with busy_o=0 in that same cycle.
  - A new start_i is accepted in that cycle.
- Total unstalled latency from start to done: ROWS+PE_SIZE+2 cycles.
- Almost-full sampled high in cycle c suppresses the read in cycle c only (combinational gate on mem_ce_o). A read resumes in the first cycle afull is low.
- Reset asserted mid-transfer: all outputs go to reset values immediately (async). No done_o is produced and in-flight skew data is discarded.

## Test plan
- Basic, PE_SIZE=4, ROWS=4, base=0x010, BRAM word k = {8'hk0,8'hk1,8'hk2,8'hk3}, start in cycle 0:
  - Reads are issued at addresses 0x010..0x013 in cycles 1..4.
  - Lane 0 writes 0x00,0x10,0x20,0x30 in cycles 3..6.
  - Lane 3 writes 0x03,0x13,0x23,0x33 in cycles 6..9.
  - done_o is high in cycle 10.
- Back-pressure: same setup with fifo_afull_i[2]=1 during cycles 2–3:
  - Reads are issued in cycles 1,4,5,6 at 0x010..0x013.
  - Lane data order is unchanged.
  - done_o is high in cycle 12.
- Address wrap, MEM_ADDR_WIDTH=10, base=0x3FE, ROWS=4 -> reads at 0x3FE,0x3FF,0x000,0x001; data is correct.
- start_i pulsed in cycles 3 and 7 during a transfer -> ignored. Exactly one done_o, and the addresses are unaffected.
- Back-to-back: start_i in the done_o cycle -> the next READ begins the following cycle. Both transfers are complete, with no lost or duplicated wren_o.
- Reset mid-run: rst_n low in cycle 5 -> all wren_o and mem_ce_o drop immediately, with no done_o. A subsequent start completes normally.

Source files
------------

// File: rtl/sa_input_loader_if.sv
// sa_input_loader_if: bundles the loader's control handshake, BRAM read port and
// per-lane FIFO write port.
//   control : start_i, base_addr_i -> busy_o, done_o
//   BRAM    : mem_ce_o, mem_addr_o -> mem_q_i (one-cycle read latency)
//   FIFOs   : fifo_afull_i -> wren_o, wdata_o (lane i at MSB-first slice i)
// master is the loader side; slave is the environment (controller, BRAM, FIFOs).
interface sa_input_loader_if #(
  parameter int unsigned FIFO_DATA_WIDTH = 8,
  parameter int unsigned PE_SIZE         = 16,
  parameter int unsigned MEM_ADDR_WIDTH  = 10,
  parameter int unsigned MEM_DATA_WIDTH  = 128
);
  logic                                 start_i;
  logic [MEM_ADDR_WIDTH-1:0]            base_addr_i;
  logic                                 busy_o;
  logic                                 done_o;
  logic                                 mem_ce_o;
  logic [MEM_ADDR_WIDTH-1:0]            mem_addr_o;
  logic [MEM_DATA_WIDTH-1:0]            mem_q_i;
  logic [PE_SIZE-1:0]                   fifo_afull_i;
  logic [PE_SIZE-1:0]                   wren_o;
  logic [FIFO_DATA_WIDTH*PE_SIZE-1:0]   wdata_o;

  modport master (
    input  start_i, base_addr_i, mem_q_i, fifo_afull_i,
    output busy_o, done_o, mem_ce_o, mem_addr_o, wren_o, wdata_o
  );

  modport slave (
    output start_i, base_addr_i, mem_q_i, fifo_afull_i,
    input  busy_o, done_o, mem_ce_o, mem_addr_o, wren_o, wdata_o
  );
endinterface

// File: rtl/sa_input_loader.sv
// sa_input_loader: reads ROWS words from BRAM starting at a captured base address
// and streams them into PE_SIZE per-lane FIFOs, lane i delayed by i cycles so the
// systolic array sees a diagonal wavefront.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sa_input_loader_if.master (control, BRAM read port, FIFO write port)
// MEM_DATA_WIDTH must equal FIFO_DATA_WIDTH*PE_SIZE. Almost-full only gates new
// reads; the skew pipeline never stalls, so FIFOs need PE_SIZE+1 spare entries.
module sa_input_loader #(
  parameter int unsigned FIFO_DATA_WIDTH = 8,
  parameter int unsigned PE_SIZE         = 16,
  parameter int unsigned MEM_ADDR_WIDTH  = 10,
  parameter int unsigned MEM_DATA_WIDTH  = 128,
  parameter int unsigned ROWS            = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sa_input_loader_if.master    bus
);
  localparam int unsigned CntW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DrnW = $clog2(PE_SIZE + 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                    state_d, state_q;
  logic [MEM_ADDR_WIDTH-1:0] base_d, base_q;
  logic [CntW-1:0]           rd_cnt_d, rd_cnt_q;
  logic [DrnW-1:0]           drn_cnt_d, drn_cnt_q;
  logic                      done_d, done_q;
  logic                      rd_issue;
  // High in the cycle BRAM data for an issued read is on mem_q_i.
  logic                      rd_pend_q;

  logic [PE_SIZE-1:0]        wren;
  logic [MEM_DATA_WIDTH-1:0] wdata;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    rd_cnt_d  = rd_cnt_q;
    drn_cnt_d = drn_cnt_q;
    done_d    = 1'b0;
    rd_issue  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          base_d   = bus.base_addr_i;
          rd_cnt_d = '0;
          state_d  = StRead;
        end
      end
      StRead: begin
        if (~|bus.fifo_afull_i) begin
          rd_issue = 1'b1;
          if (rd_cnt_q == CntW'(ROWS - 1)) begin
            drn_cnt_d = '0;
            state_d   = StDrain;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        // PE_SIZE+1 cycles lets the last word clear the deepest lane.
        if (drn_cnt_q == DrnW'(PE_SIZE)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          drn_cnt_d = drn_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      base_q    <= '0;
      rd_cnt_q  <= '0;
      drn_cnt_q <= '0;
      done_q    <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      rd_cnt_q  <= rd_cnt_d;
      drn_cnt_q <= drn_cnt_d;
      done_q    <= done_d;
      rd_pend_q <= rd_issue;
    end
  end

  // Per-lane skew: stage 0 captures the BRAM word, lane i adds i more stages.
  // Data registers load only with valid, so idle lanes hold their last value.
  for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
    logic [i:0]                 vld_d, vld_q;
    logic [FIFO_DATA_WIDTH-1:0] dat_d [i+1];
    logic [FIFO_DATA_WIDTH-1:0] dat_q [i+1];

    always_comb begin
      vld_d[0] = rd_pend_q;
      dat_d[0] = rd_pend_q ? bus.mem_q_i[MEM_DATA_WIDTH-1-i*FIFO_DATA_WIDTH -: FIFO_DATA_WIDTH]
                           : dat_q[0];
      for (int j = 1; j <= i; j++) begin
        vld_d[j] = vld_q[j-1];
        dat_d[j] = vld_q[j-1] ? dat_q[j-1] : dat_q[j];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int j = 0; j <= i; j++) dat_q[j] <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign wren[i] = vld_q[i];
    assign wdata[MEM_DATA_WIDTH-1-i*FIFO_DATA_WIDTH -: FIFO_DATA_WIDTH] = dat_q[i];
  end

  assign bus.mem_ce_o   = rd_issue;
  assign bus.mem_addr_o = base_q + MEM_ADDR_WIDTH'(rd_cnt_q);
  assign bus.wren_o     = wren;
  assign bus.wdata_o    = wdata;
  assign bus.busy_o     = (state_q != StIdle);
  assign bus.done_o     = done_q;
endmodule

// File: tb/tb_sa_input_loader.sv
module tb_sa_input_loader;
  localparam int unsigned FW   = 8;
  localparam int unsigned PE   = 4;
  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned ROWS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_input_loader_if #(
    .FIFO_DATA_WIDTH(FW), .PE_SIZE(PE), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)
  ) bus ();

  sa_input_loader #(
    .FIFO_DATA_WIDTH(FW), .PE_SIZE(PE), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .ROWS(ROWS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // BRAM content: lane i byte of word at address a is {a[3:0], i}.
  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < PE; i++) w[DW-1-8*i -: 8] = {a[3:0], 4'(i)};
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.mem_q_i <= '0;
    else if (bus.mem_ce_o) bus.mem_q_i <= word(bus.mem_addr_o);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [31:0] val;} exp_t;
  typedef struct {int cyc; logic [AW-1:0] base;} st_t;
  typedef struct {
    logic [AW-1:0] base; logic [PE-1:0] af_mask; int af_from; int af_to;
    int spur_a; int spur_b; int done_rel;
  } vec_t;

  exp_t q_rd[$];
  exp_t q_ln[PE][$];
  int   q_done[$];
  st_t  starts[$];
  int   spur[$];
  int   af_from = 0, af_to = -1;
  logic [PE-1:0] af_mask = '0;
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic extra(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at cyc %0d, want none", nm, cyc);
  endtask

  // Scoreboard: every observed event pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_ce_o) begin
      if (q_rd.size() == 0) extra("rd_extra");
      else begin
        e = q_rd.pop_front();
        chk("rd_cyc", cyc, e.cyc);
        chk("rd_addr", 32'(bus.mem_addr_o), e.val);
      end
    end
    for (int i = 0; i < PE; i++) begin
      if (bus.wren_o[i]) begin
        if (q_ln[i].size() == 0) extra($sformatf("lane%0d_extra", i));
        else begin
          e = q_ln[i].pop_front();
          chk($sformatf("lane%0d_cyc", i), cyc, e.cyc);
          chk($sformatf("lane%0d_data", i), 32'(bus.wdata_o[DW-1-8*i -: 8]), e.val);
        end
      end
    end
    if (bus.done_o) begin
      if (q_done.size() == 0) extra("done_extra");
      else chk("done_cyc", cyc, q_done.pop_front());
      chk("busy_at_done", 32'(bus.busy_o), 0);
    end
  end

  // Reference model: reads fill the first ROWS cycles after start not blocked by afull.
  task automatic plan(input int c0, input logic [AW-1:0] base, input int done_rel);
    int c;
    int n;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    c = c0 + 1;
    n = 0;
    while (n < int'(ROWS)) begin
      if (!(af_mask != '0 && c >= af_from && c <= af_to)) begin
        a = base + AW'(n);
        w = word(a);
        q_rd.push_back('{c, 32'(a)});
        for (int i = 0; i < PE; i++) q_ln[i].push_back('{c + 2 + i, 32'(w[DW-1-8*i -: 8])});
        n++;
      end
      c++;
    end
    q_done.push_back(c0 + done_rel);
    starts.push_back('{c0, base});
  endtask

  task automatic drive(input int last);
    while (cyc < last) begin
      @(posedge clk);
      #1;
      bus.start_i     = 1'b0;
      bus.base_addr_i = 10'h155;
      foreach (starts[k]) if (starts[k].cyc == cyc) begin
        bus.start_i     = 1'b1;
        bus.base_addr_i = starts[k].base;
      end
      foreach (spur[k]) if (spur[k] == cyc) bus.start_i = 1'b1;
      bus.fifo_afull_i = (cyc >= af_from && cyc <= af_to) ? af_mask : '0;
      foreach (starts[k]) if (starts[k].cyc + 1 == cyc) chk("busy_after_start", 32'(bus.busy_o), 1);
    end
  endtask

  task automatic check_drained();
    chk("rd_left", q_rd.size(), 0);
    for (int i = 0; i < PE; i++) chk($sformatf("lane%0d_left", i), q_ln[i].size(), 0);
    chk("done_left", q_done.size(), 0);
    chk("busy_idle", 32'(bus.busy_o), 0);
    starts.delete();
    spur.delete();
    af_from = 0;
    af_to   = -1;
    af_mask = '0;
  endtask

  vec_t vt[7];
  int   c0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    vt[0] = '{10'h010, 4'b0000, 0, -1, -1, -1, 10};  // basic
    vt[1] = '{10'h010, 4'b0100, 2,  3, -1, -1, 12};  // back-pressure lane 2
    vt[2] = '{10'h3FE, 4'b0000, 0, -1, -1, -1, 10};  // address wrap
    vt[3] = '{10'h020, 4'b0000, 0, -1,  3,  7, 10};  // start while busy ignored
    vt[4] = '{10'h030, 4'b1000, 5,  9, -1, -1, 10};  // afull in DRAIN ignored
    vt[5] = '{10'h050, 4'b0001, 1,  1, -1, -1, 11};  // afull on first read cycle
    vt[6] = '{10'h060, 4'b1111, 1,  4, -1, -1, 14};  // all lanes full for 4 cycles

    bus.start_i = 1'b0;
    bus.base_addr_i = '0;
    bus.fifo_afull_i = '0;
    #1;
    chk("rst_ce", 32'(bus.mem_ce_o), 0);
    chk("rst_addr", 32'(bus.mem_addr_o), 0);
    chk("rst_wren", 32'(bus.wren_o), 0);
    chk("rst_wdata", bus.wdata_o, 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      c0 = cyc + 1;
      af_from = c0 + vt[v].af_from;
      af_to   = c0 + vt[v].af_to;
      af_mask = vt[v].af_mask;
      if (vt[v].spur_a >= 0) spur.push_back(c0 + vt[v].spur_a);
      if (vt[v].spur_b >= 0) spur.push_back(c0 + vt[v].spur_b);
      plan(c0, vt[v].base, vt[v].done_rel);
      drive(c0 + vt[v].done_rel + 2);
      check_drained();
    end

    // Back-to-back: second start lands in the done cycle of the first.
    c0 = cyc + 1;
    plan(c0, 10'h040, 10);
    plan(c0 + 10, 10'h080, 10);
    drive(c0 + 22);
    check_drained();

    // Reset in cycle 5 of a transfer: outputs clear at once, no done.
    c0 = cyc + 1;
    plan(c0, 10'h100, 10);
    drive(c0 + 4);
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.start_i = 1'b0;
    #1;
    chk("mid_rst_wren", 32'(bus.wren_o), 0);
    chk("mid_rst_ce", 32'(bus.mem_ce_o), 0);
    chk("mid_rst_busy", 32'(bus.busy_o), 0);
    chk("mid_rst_addr", 32'(bus.mem_addr_o), 0);
    chk("mid_rst_wdata", bus.wdata_o, 0);
    chk("mid_rst_reads_issued", q_rd.size(), 0);
    for (int i = 0; i < PE; i++) q_ln[i].delete();
    q_done.delete();
    starts.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(cyc + 12);
    check_drained();

    c0 = cyc + 1;
    plan(c0, 10'h200, 10);
    drive(c0 + 12);
    check_drained();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
